arith_error_monitor: RTL and testbench

ARITH_ERROR_MONITOR -- requirements
Module: arith_error_monitor

---
 rtl/arith_error_monitor_if.sv | 29 ++
 rtl/arith_error_monitor.sv | 160 ++++++++++++++++
 tb/tb_arith_error_monitor.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_error_monitor_if.sv
// Bus bundle between an arithmetic core/driver and arith_error_monitor.
// The master drives the operation handshake; the slave (monitor) reports status.
interface arith_error_monitor_if #(
    parameter int WORD_LENGTH = 16,
    parameter int CNT_WIDTH   = 8
);
    logic                       start;
    logic [1:0]                 opcode;
    logic [WORD_LENGTH-1:0]     operand_y;
    logic [2*WORD_LENGTH-1:0]   result_wide;
    logic                       done;
    logic                       clear;
    logic                       busy;
    logic                       error;
    logic [2:0]                 error_code;
    logic                       error_pulse;
    logic                       ok_pulse;
    logic [CNT_WIDTH-1:0]       err_count;

    modport master (
        output start, opcode, operand_y, result_wide, done, clear,
        input  busy, error, error_code, error_pulse, ok_pulse, err_count
    );

    modport slave (
        input  start, opcode, operand_y, result_wide, done, clear,
        output busy, error, error_code, error_pulse, ok_pulse, err_count
    );
endinterface

// File: rtl/arith_error_monitor.sv
// Watches one MUL/DIV/SQRT operation at a time: screens operands at start,
// checks the MUL product range and completion deadline, and latches the first error.
module arith_error_monitor #(
    parameter int WORD_LENGTH = 16,
    parameter int TIMEOUT     = 64,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    arith_error_monitor_if.slave  bus
);
    localparam int W      = WORD_LENGTH;
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [W-1:0]         Y_ZERO    = {W{1'b0}};

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] CODE_NONE    = 3'b000;
    localparam logic [2:0] CODE_MUL_OVF = 3'b001;
    localparam logic [2:0] CODE_DIV0    = 3'b010;
    localparam logic [2:0] CODE_NEG_SQ  = 3'b011;
    localparam logic [2:0] CODE_ILLEGAL = 3'b100;
    localparam logic [2:0] CODE_TIMEOUT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    // Product fits the W-bit signed range exactly when bits [2W-1:W-1] are a pure sign extension.
    function automatic logic mul_overflow(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] max_v;
        logic signed [2*W-1:0] min_v;
        max_v = {{(W+1){1'b0}}, {(W-1){1'b1}}};
        min_v = {{(W+1){1'b1}}, {(W-1){1'b0}}};
        return (p > max_v) || (p < min_v);
    endfunction

    state_t                state_r,     state_s;
    logic [1:0]            op_r,        op_s;
    logic [2:0]            code_r,      code_s;
    logic [WAIT_W-1:0]     wait_cnt_r,  wait_cnt_s;
    logic [CNT_WIDTH-1:0]  err_count_r, err_count_s;
    logic                  error_pulse_r;
    logic                  ok_pulse_r;
    logic                  enter_err_s;
    logic                  ok_s;

    // State register and all datapath/status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            op_r          <= OP_MUL;
            code_r        <= CODE_NONE;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            err_count_r   <= {CNT_WIDTH{1'b0}};
            error_pulse_r <= 1'b0;
            ok_pulse_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            op_r          <= op_s;
            code_r        <= code_s;
            wait_cnt_r    <= wait_cnt_s;
            err_count_r   <= err_count_s;
            error_pulse_r <= enter_err_s;
            ok_pulse_r    <= ok_s;
        end
    end

    // Next-state, error classification and completion decisions.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        code_s      = code_r;
        wait_cnt_s  = wait_cnt_r;
        enter_err_s = 1'b0;
        ok_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    op_s       = bus.opcode;
                    wait_cnt_s = {WAIT_W{1'b0}};
                    if (bus.opcode == OP_RSVD) begin
                        state_s     = ST_ERROR;
                        code_s      = CODE_ILLEGAL;
                        enter_err_s = 1'b1;
                    end else if ((bus.opcode == OP_DIV) && (bus.operand_y == Y_ZERO)) begin
                        state_s     = ST_ERROR;
                        code_s      = CODE_DIV0;
                        enter_err_s = 1'b1;
                    end else if ((bus.opcode == OP_SQRT) && bus.operand_y[W-1]) begin
                        state_s     = ST_ERROR;
                        code_s      = CODE_NEG_SQ;
                        enter_err_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    code_s = CODE_NONE;
                end
            end

            ST_WAIT: begin
                // done wins over a deadline expiring on the same edge.
                if (bus.done) begin
                    if ((op_r == OP_MUL) && mul_overflow(bus.result_wide)) begin
                        state_s     = ST_ERROR;
                        code_s      = CODE_MUL_OVF;
                        enter_err_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        ok_s    = 1'b1;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s     = ST_ERROR;
                    code_s      = CODE_TIMEOUT;
                    enter_err_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 1'b1;
                end
            end

            ST_ERROR: begin
                if (bus.clear) begin
                    state_s = ST_IDLE;
                    code_s  = CODE_NONE;
                end else begin
                    state_s = ST_ERROR;
                end
            end

            default: begin
                state_s = ST_IDLE;
                code_s  = CODE_NONE;
            end
        endcase

        if (enter_err_s && (err_count_r != CNT_MAX)) begin
            err_count_s = err_count_r + 1'b1;
        end else begin
            err_count_s = err_count_r;
        end
    end

    assign bus.busy        = (state_r == ST_WAIT);
    assign bus.error       = (state_r == ST_ERROR);
    assign bus.error_code  = (state_r == ST_ERROR) ? code_r : CODE_NONE;
    assign bus.error_pulse = error_pulse_r;
    assign bus.ok_pulse    = ok_pulse_r;
    assign bus.err_count   = err_count_r;

endmodule

// File: tb/tb_arith_error_monitor.sv
// Self-checking bench for arith_error_monitor (W=16, TIMEOUT=4): directed vector
// table, hand-written reset/saturation sequences and randomized traffic against a model.
module tb_arith_error_monitor;
    localparam int W   = 16;
    localparam int TO  = 4;
    localparam int CW  = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    arith_error_monitor_if #(.WORD_LENGTH(W), .CNT_WIDTH(CW)) bus ();

    arith_error_monitor #(.WORD_LENGTH(W), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [1:0]  opcode;
        logic [15:0] y;
        logic [31:0] rw;
        logic        done;
        logic        clear;
        logic        e_busy;
        logic        e_err;
        logic [2:0]  e_code;
        logic        e_ep;
        logic        e_ok;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: an outstanding-operation flag, its age and a latched cause.
    bit m_pending;
    int m_age;
    int m_op;
    int m_code;
    int m_cnt;
    bit m_ep;
    bit m_ok;

    task automatic add(input int unsigned s, input int unsigned op, input int unsigned y,
                       input int unsigned rw, input int unsigned d, input int unsigned c,
                       input int unsigned eb, input int unsigned ee, input int unsigned ec,
                       input int unsigned ep, input int unsigned ok, input int unsigned cnt);
        vec_t v;
        v.start = s[0];   v.opcode = op[1:0]; v.y = y[15:0]; v.rw = rw;
        v.done  = d[0];   v.clear  = c[0];
        v.e_busy = eb[0]; v.e_err = ee[0]; v.e_code = ec[2:0];
        v.e_ep = ep[0];   v.e_ok = ok[0];  v.e_cnt = cnt[7:0];
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic eb, input logic ee, input logic [2:0] ec,
                             input logic eep, input logic eok, input logic [7:0] ecnt);
        check({tag, ".busy"},        {31'b0, bus.busy},        {31'b0, eb});
        check({tag, ".error"},       {31'b0, bus.error},       {31'b0, ee});
        check({tag, ".error_code"},  {29'b0, bus.error_code},  {29'b0, ec});
        check({tag, ".error_pulse"}, {31'b0, bus.error_pulse}, {31'b0, eep});
        check({tag, ".ok_pulse"},    {31'b0, bus.ok_pulse},    {31'b0, eok});
        check({tag, ".err_count"},   {24'b0, bus.err_count},   {24'b0, ecnt});
    endtask

    task automatic set_in(input logic s, input logic [1:0] op, input logic [15:0] y,
                          input logic [31:0] rw, input logic d, input logic c);
        bus.start = s; bus.opcode = op; bus.operand_y = y;
        bus.result_wide = rw; bus.done = d; bus.clear = c;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_age = 0; m_op = 0; m_code = 0; m_cnt = 0; m_ep = 1'b0; m_ok = 1'b0;
    endtask

    task automatic model_raise(input int c);
        m_code = c;
        m_ep   = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_edge(input logic s, input logic [1:0] op, input logic [15:0] y,
                              input logic [31:0] rw, input logic d, input logic c);
        longint prod;
        m_ep = 1'b0;
        m_ok = 1'b0;
        prod = longint'($signed(rw));
        if (m_code != 0) begin
            if (c) m_code = 0;
        end else if (m_pending) begin
            if (d) begin
                m_pending = 1'b0;
                if (m_op == 0 && (prod > 32767 || prod < -32768)) model_raise(1);
                else m_ok = 1'b1;
            end else begin
                m_age++;
                if (m_age >= TO) begin
                    m_pending = 1'b0;
                    model_raise(5);
                end
            end
        end else if (s) begin
            m_op = int'(op);
            if (op == 2'd3)                        model_raise(4);
            else if (op == 2'd1 && y == 16'd0)     model_raise(2);
            else if (op == 2'd2 && $signed(y) < 0) model_raise(3);
            else begin
                m_pending = 1'b1;
                m_age     = 0;
            end
        end
    endtask

    initial begin
        logic        r_s, r_d, r_c;
        logic [1:0]  r_op;
        logic [15:0] r_y;
        logic [31:0] r_rw;
        logic [31:0] bnd[4];
        int          sel;
        n_checks = 0;
        n_errors = 0;
        bnd[0] = 32'h00007FFF; bnd[1] = 32'h00008000; bnd[2] = 32'hFFFF8000; bnd[3] = 32'hFFFF7FFF;

        // Directed table: inputs for one edge, outputs expected after it.
        //   s op  y          rw            d  c   busy err code ep ok cnt
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 32'h00007FFF, 1, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 32'hFFFF8000, 1, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 32'h00008000, 1, 0,  0, 1, 1, 1, 0, 1);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  0, 1, 1, 0, 0, 1);
        add(0, 0, 16'h0000, 32'h00000000, 0, 1,  0, 0, 0, 0, 0, 1);
        add(1, 1, 16'h0000, 32'h00000000, 0, 0,  0, 1, 2, 1, 0, 2);
        add(0, 0, 16'h0000, 32'h00000000, 0, 1,  0, 0, 0, 0, 0, 2);
        add(1, 2, 16'h8000, 32'h00000000, 0, 0,  0, 1, 3, 1, 0, 3);
        add(0, 0, 16'h0000, 32'h00000000, 0, 1,  0, 0, 0, 0, 0, 3);
        add(1, 3, 16'h1234, 32'h00000000, 0, 0,  0, 1, 4, 1, 0, 4);
        add(0, 0, 16'h0000, 32'h00000000, 0, 1,  0, 0, 0, 0, 0, 4);
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 4);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 4);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 4);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 4);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  0, 1, 5, 1, 0, 5);
        add(0, 0, 16'h0000, 32'h00000000, 0, 1,  0, 0, 0, 0, 0, 5);
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'h00000000, 1, 0,  0, 0, 0, 0, 1, 5);
        add(1, 1, 16'h0005, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'h12345678, 1, 0,  0, 0, 0, 0, 1, 5);
        add(1, 2, 16'h7FFF, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'h80000000, 1, 0,  0, 0, 0, 0, 1, 5);
        add(0, 0, 16'h0000, 32'h00008000, 1, 1,  0, 0, 0, 0, 0, 5);
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 5);
        add(1, 3, 16'h0000, 32'h00000000, 0, 1,  1, 0, 0, 0, 0, 5);
        add(0, 0, 16'h0000, 32'hFFFF7FFF, 1, 0,  0, 1, 1, 1, 0, 6);
        add(1, 0, 16'h0000, 32'h00000000, 0, 0,  0, 1, 1, 0, 0, 6);
        add(1, 3, 16'h0000, 32'h00000000, 0, 1,  0, 0, 0, 0, 0, 6);
        add(0, 0, 16'h0000, 32'h00000000, 0, 0,  0, 0, 0, 0, 0, 6);
        add(1, 1, 16'hFFFF, 32'h00000000, 0, 0,  1, 0, 0, 0, 0, 6);
        add(0, 0, 16'h0000, 32'h00000000, 1, 0,  0, 0, 0, 0, 1, 6);

        reset = 1'b0;
        set_in(1'b0, 2'd0, 16'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_all("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            set_in(vecs[i].start, vecs[i].opcode, vecs[i].y, vecs[i].rw, vecs[i].done, vecs[i].clear);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_err, vecs[i].e_code,
                      vecs[i].e_ep, vecs[i].e_ok, vecs[i].e_cnt);
        end

        // Reset in the middle of WAIT_DONE, then a normal start.
        set_in(1'b1, 2'd0, 16'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_all("pre_rst_wait", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd6);
        #2 reset = 1'b0;
        #1 check_all("rst_in_wait", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b1, 2'd0, 16'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_all("post_rst_start", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        set_in(1'b0, 2'd0, 16'h0, 32'h00008000, 1'b1, 1'b0);
        tick();
        check_all("post_rst_ovf", 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'd1);
        set_in(1'b0, 2'd0, 16'h0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 check_all("rst_in_error", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_all("idle_after_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);

        // Counter saturation over 260 error entries.
        for (int i = 1; i <= 260; i++) begin
            set_in(1'b1, 2'd3, 16'h0, 32'h0, 1'b0, 1'b0);
            tick();
            check("sat_cnt", {24'b0, bus.err_count}, (i < 255) ? i : 255);
            set_in(1'b0, 2'd0, 16'h0, 32'h0, 1'b0, 1'b1);
            tick();
        end

        // Randomized traffic against the model, from a fresh reset.
        reset = 1'b0;
        set_in(1'b0, 2'd0, 16'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            r_s  = ($urandom_range(0, 1) == 0);
            r_op = 2'($urandom_range(0, 3));
            r_y  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            r_d  = ($urandom_range(0, 9) < 3);
            r_c  = ($urandom_range(0, 9) < 3);
            sel  = $urandom_range(0, 2);
            if (sel == 0)      r_rw = $urandom;
            else if (sel == 1) r_rw = 32'($signed(16'($urandom)));
            else               r_rw = bnd[$urandom_range(0, 3)];
            set_in(r_s, r_op, r_y, r_rw, r_d, r_c);
            model_edge(r_s, r_op, r_y, r_rw, r_d, r_c);
            tick();
            check_all("rand", m_pending, (m_code != 0), 3'(m_code), m_ep, m_ok, 8'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
